// File: rtl/hbconmux_pkg.sv
// hbconmux_pkg: shared constants and helpers for the hexbus/console mux.
//   HB_TAG / CON_TAG : value of tx byte bit 7 for hexbus / console traffic.
//   burst_w()        : width of the hexbus burst counter for a given limit.
// Optional feature macro used by hbconmux: HBCONMUX_FAIRNESS_EN.
package hbconmux_pkg;
  localparam logic HB_TAG  = 1'b1;
  localparam logic CON_TAG = 1'b0;

  // Counter must be able to hold the value HB_BURST itself (saturation point).
  function automatic int burst_w(input int hb_burst);
    return (hb_burst < 1) ? 1 : $clog2(hb_burst + 1);
  endfunction
endpackage

// File: rtl/hbconfifo.sv
// hbconfifo: console transmit FIFO, 7-bit wide, 2^LGFIFO deep, first-word
// fall-through (o_data is the head whenever !o_empty).
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_push, i_data  write request (ignored when full, even with a same-cycle pop)
//   i_pop           read request (ignored when empty)
//   o_data          current head
//   o_fill          registered occupancy, 0..2^LGFIFO
//   o_full, o_empty decoded from o_fill
module hbconfifo #(
  parameter int LGFIFO = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_push,
  input  logic [6:0]        i_data,
  input  logic              i_pop,
  output logic [6:0]        o_data,
  output logic [LGFIFO:0]   o_fill,
  output logic              o_full,
  output logic              o_empty
);
  import hbconmux_pkg::*;

  localparam logic [LGFIFO:0] DEPTH = {1'b1, {LGFIFO{1'b0}}};

  logic [6:0]        r_mem [0:(1<<LGFIFO)-1];
  logic [LGFIFO-1:0] r_wr, r_rd;
  logic [LGFIFO:0]   r_fill;
  logic              w_push, w_pop;

  assign o_full  = (r_fill == DEPTH);
  assign o_empty = (r_fill == '0);
  assign o_fill  = r_fill;
  assign o_data  = r_mem[r_rd];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Storage needs no reset; pointers and fill define what is valid.
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wr] <= i_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_fill <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + LGFIFO'(1);
      if (w_pop)  r_rd <= r_rd + LGFIFO'(1);
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + (LGFIFO+1)'(1);
        2'b01:   r_fill <= r_fill - (LGFIFO+1)'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end
endmodule

// File: rtl/hbconmux.sv
// hbconmux: muxes hexbus debug bytes (bit 7 set) and buffered console bytes
// (bit 7 clear) onto one UART transmit stream, and splits received bytes by
// the same tag.
// Ports:
//   i_clk, i_reset                   clock, synchronous active-high reset
//   i_hb_stb/i_hb_byte, o_hb_busy    hexbus tx byte in; busy = not taken
//   i_console_stb/i_console_data     console tx byte into FIFO
//   o_console_busy, o_console_fill   FIFO full flag / occupancy
//   o_tx_stb/o_tx_data, i_tx_busy    output register toward the UART
//   i_rx_stb/i_rx_byte               byte from the UART receiver
//   o_hb_rx_stb/o_hb_rx_byte         received hexbus byte (bit 7 cleared)
//   o_console_stb/o_console_data     received console byte
// Macro HBCONMUX_FAIRNESS_EN: when defined, after HB_BURST hexbus bytes with
// console data waiting, one console byte is forced out. When undefined the
// hexbus has strict priority.
module hbconmux #(
  parameter int LGFIFO   = 5,
  parameter int HB_BURST = 8
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_hb_stb,
  input  logic [6:0]      i_hb_byte,
  output logic            o_hb_busy,
  input  logic            i_console_stb,
  input  logic [6:0]      i_console_data,
  output logic            o_console_busy,
  output logic [LGFIFO:0] o_console_fill,
  output logic            o_tx_stb,
  output logic [7:0]      o_tx_data,
  input  logic            i_tx_busy,
  input  logic            i_rx_stb,
  input  logic [7:0]      i_rx_byte,
  output logic            o_hb_rx_stb,
  output logic [7:0]      o_hb_rx_byte,
  output logic            o_console_stb,
  output logic [6:0]      o_console_data
);
  import hbconmux_pkg::*;

  logic       r_tx_stb;
  logic [7:0] r_tx_data;
  logic [6:0] w_fifo_data;
  logic       w_fifo_empty, w_fifo_full;
  logic       w_load_ok, w_force_con, w_hb_load, w_con_load;

  hbconfifo #(.LGFIFO(LGFIFO)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (i_console_stb),
    .i_data  (i_console_data),
    .i_pop   (w_con_load),
    .o_data  (w_fifo_data),
    .o_fill  (o_console_fill),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign o_console_busy = w_fifo_full;

  // The output register may reload in the same cycle its byte is taken.
  assign w_load_ok  = !r_tx_stb || !i_tx_busy;
  assign w_hb_load  = w_load_ok && i_hb_stb && !w_force_con;
  assign w_con_load = w_load_ok && !w_hb_load && !w_fifo_empty;
  assign o_hb_busy  = !w_load_ok || w_force_con;

`ifdef HBCONMUX_FAIRNESS_EN
  localparam int              BW   = burst_w(HB_BURST);
  localparam logic [BW-1:0]   BMAX = BW'(HB_BURST);
  logic [BW-1:0] r_burst;

  assign w_force_con = !w_fifo_empty && (r_burst == BMAX);

  // Counts hexbus loads made while console data waits; any console load or
  // an empty FIFO restarts the count.
  always_ff @(posedge i_clk) begin
    if (i_reset)                        r_burst <= '0;
    else if (w_fifo_empty || w_con_load) r_burst <= '0;
    else if (w_hb_load && r_burst != BMAX) r_burst <= r_burst + BW'(1);
  end
`else
  assign w_force_con = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tx_stb  <= 1'b0;
      r_tx_data <= '0;
    end else if (w_load_ok) begin
      if (w_hb_load) begin
        r_tx_stb  <= 1'b1;
        r_tx_data <= {HB_TAG, i_hb_byte};
      end else if (w_con_load) begin
        r_tx_stb  <= 1'b1;
        r_tx_data <= {CON_TAG, w_fifo_data};
      end else begin
        r_tx_stb  <= 1'b0;
      end
    end
  end

  assign o_tx_stb  = r_tx_stb;
  assign o_tx_data = r_tx_data;

  // RX demux: strobes steered by the tag bit, data loaded every cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_hb_rx_stb    <= 1'b0;
      o_console_stb  <= 1'b0;
      o_hb_rx_byte   <= '0;
      o_console_data <= '0;
    end else begin
      o_hb_rx_stb    <= i_rx_stb && (i_rx_byte[7] == HB_TAG);
      o_console_stb  <= i_rx_stb && (i_rx_byte[7] == CON_TAG);
      o_hb_rx_byte   <= {1'b0, i_rx_byte[6:0]};
      o_console_data <= i_rx_byte[6:0];
    end
  end
endmodule

// File: tb/tb_hbconmux.sv
module tb_hbconmux;
  localparam int LG = 5;
  localparam int B  = 8;
  localparam int DEPTH = 1 << LG;
`ifdef HBCONMUX_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       hb_stb, con_stb, tx_busy, rx_stb;
  logic [6:0] hb_byte, con_data;
  logic [7:0] rx_byte;
  logic       o_hb_busy, o_console_busy, o_tx_stb, o_hb_rx_stb, o_console_stb;
  logic [LG:0] o_console_fill;
  logic [7:0] o_tx_data, o_hb_rx_byte;
  logic [6:0] o_console_data;

  always #5 clk = ~clk;

  hbconmux #(.LGFIFO(LG), .HB_BURST(B)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_hb_stb(hb_stb), .i_hb_byte(hb_byte), .o_hb_busy(o_hb_busy),
    .i_console_stb(con_stb), .i_console_data(con_data),
    .o_console_busy(o_console_busy), .o_console_fill(o_console_fill),
    .o_tx_stb(o_tx_stb), .o_tx_data(o_tx_data), .i_tx_busy(tx_busy),
    .i_rx_stb(rx_stb), .i_rx_byte(rx_byte),
    .o_hb_rx_stb(o_hb_rx_stb), .o_hb_rx_byte(o_hb_rx_byte),
    .o_console_stb(o_console_stb), .o_console_data(o_console_data)
  );

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the link should carry, kept as queues.
  bit         m_tx_stb = 0;   // output register occupied
  logic [6:0] m_q[$];         // console bytes waiting
  int         m_cnt = 0;      // hexbus bytes sent since console data began waiting
  bit         m_hb_acc = 0;   // last offered hexbus byte was taken
  logic [7:0] exp_tx[$];      // bytes expected on the link, in order
  logic [8:0] exp_rx[$];      // {is_hexbus, demuxed byte}

  function automatic bit m_load_ok();
    return !m_tx_stb || !tx_busy;
  endfunction
  function automatic bit m_force();
    return FAIR && (m_q.size() > 0) && (m_cnt == B);
  endfunction

  task automatic model_update();
    bit nonempty, full, frc, hbl, conl;
    if (rst) begin
      m_tx_stb = 0; m_q.delete(); m_cnt = 0; m_hb_acc = 0;
      exp_tx.delete(); exp_rx.delete();
      return;
    end
    nonempty = m_q.size() > 0;
    full     = m_q.size() == DEPTH;
    frc      = m_force();
    hbl = 0; conl = 0;
    if (m_load_ok()) begin
      if (hb_stb && !frc) begin
        exp_tx.push_back({1'b1, hb_byte}); m_tx_stb = 1; hbl = 1;
      end else if (nonempty) begin
        exp_tx.push_back({1'b0, m_q.pop_front()}); m_tx_stb = 1; conl = 1;
      end else m_tx_stb = 0;
    end
    m_hb_acc = hbl;
    if (!nonempty || conl) m_cnt = 0;
    else if (hbl && m_cnt < B) m_cnt++;
    if (con_stb && !full) m_q.push_back(con_data);
    if (rx_stb) exp_rx.push_back({rx_byte[7], 1'b0, rx_byte[6:0]});
  endtask

  // One clock: compare combinational/registered flags, then advance.
  task automatic cycle();
    #1;
    check("hb_busy", o_hb_busy, !m_load_ok() || m_force());
    check("con_fill", o_console_fill, m_q.size());
    check("con_busy", o_console_busy, m_q.size() == DEPTH);
    check("tx_stb", o_tx_stb, m_tx_stb);
    @(posedge clk); #1;
    model_update();
  endtask

  task automatic do_reset(input int n);
    rst = 1; hb_stb = 0; con_stb = 0; rx_stb = 0;
    repeat (n) begin @(posedge clk); #1; model_update(); end
    rst = 0;
  endtask

  bit  seq_mode = 0;
  int  seq_k = 0;

  task automatic run(input int n, input int p_hb, input int p_con, input int p_busy, input int p_rx);
    for (int i = 0; i < n; i++) begin
      // an offered hexbus byte must be held until it is taken
      if (!(hb_stb && !m_hb_acc)) begin
        hb_stb = ($urandom_range(99) < p_hb);
        if (seq_mode && hb_stb) begin hb_byte = 7'h41 + 7'(seq_k); seq_k++; end
        else hb_byte = 7'($urandom);
      end
      con_stb  = ($urandom_range(99) < p_con);
      con_data = 7'($urandom);
      tx_busy  = ($urandom_range(99) < p_busy);
      rx_stb   = ($urandom_range(99) < p_rx);
      rx_byte  = 8'($urandom);
      cycle();
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents something.
  bit         held_prev = 0;
  logic [7:0] held_data;
  always @(negedge clk) begin
    if (held_prev) check("tx_hold", o_tx_data, held_data);
    held_prev = !rst && (o_tx_stb === 1'b1) && tx_busy;
    held_data = o_tx_data;
    if (!rst && o_tx_stb === 1'b1 && !tx_busy) begin
      if (exp_tx.size() == 0) check("tx_extra", o_tx_data, 32'hFFFF_FFFF);
      else check("tx_data", o_tx_data, exp_tx.pop_front());
    end
    if (o_hb_rx_stb === 1'b1 || o_console_stb === 1'b1) begin
      if (exp_rx.size() == 0) check("rx_extra", {o_hb_rx_stb, o_console_stb}, 0);
      else check("rx_data",
                 o_hb_rx_stb ? {1'b1, o_hb_rx_byte} : {o_hb_rx_stb, o_console_stb, o_console_data},
                 exp_rx.pop_front() | (o_hb_rx_stb ? 9'h0 : 9'h080));
    end else if (exp_rx.size() != 0) begin
      check("rx_missing", 0, 1);
      void'(exp_rx.pop_front());
    end
  end

  initial begin
    hb_stb = 0; hb_byte = 0; con_stb = 0; con_data = 0;
    tx_busy = 0; rx_stb = 0; rx_byte = 0;
    do_reset(2);
    check("rst_tx_stb", o_tx_stb, 0);
    check("rst_tx_data", o_tx_data, 0);
    check("rst_fill", o_console_fill, 0);
    check("rst_con_busy", o_console_busy, 0);
    check("rst_hb_rx", {o_hb_rx_stb, o_hb_rx_byte}, 0);
    check("rst_con_rx", {o_console_stb, o_console_data}, 0);
    // hexbus 'A'..'D' back to back on an idle UART
    seq_mode = 1; run(4, 100, 0, 0, 0); seq_mode = 0;
    run(4, 0, 0, 0, 0);
    // single console byte, hexbus idle
    con_stb = 1; con_data = 7'h78; hb_stb = 0; tx_busy = 0; cycle();
    run(5, 0, 0, 0, 0);
    // queue console bytes, then continuous hexbus to exercise the burst limit
    run(3, 0, 100, 100, 0);
    run(60, 100, 0, 0, 0);
    run(20, 0, 0, 0, 0);
    // stalled UART: FIFO fills and further pushes are refused
    run(45, 50, 100, 100, 0);
    run(80, 0, 0, 0, 0);
    // RX demux with explicit tagged/untagged bytes
    rx_stb = 1; rx_byte = 8'hC7; con_stb = 0; hb_stb = 0; cycle();
    rx_stb = 1; rx_byte = 8'h41; cycle();
    rx_stb = 0; cycle(); cycle();
    // random mix
    run(2000, 50, 30, 30, 40);
    run(300, 90, 60, 10, 20);
    // reset with FIFO half full and the output held
    run(16, 100, 100, 100, 30);
    do_reset(1);
    check("mid_rst_tx_stb", o_tx_stb, 0);
    check("mid_rst_fill", o_console_fill, 0);
    run(300, 50, 30, 30, 40);
    // drain and confirm nothing is left outstanding
    run(120, 0, 0, 0, 0);
    check("tx_drained", exp_tx.size(), 0);
    check("fill_drained", o_console_fill, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
